// File: rtl/vec_vsetvl_unit.sv
// vec_vsetvl_unit: executes vsetvli / vsetivli / vsetvl.
// Decodes vtype, resolves AVL, computes VLMAX and vl = min(AVL, VLMAX).
// Issues a one-cycle CSR write and returns the new vl to the scalar core.
module vec_vsetvl_unit #(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] vl_in,
  output logic            csrwr_en,
  output logic [XLEN-1:0] scalar1,
  output logic [XLEN-1:0] scalar2,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            illegal_insn,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] vlin_q, vlin_d;
  logic            csrwr_en_q, csrwr_en_d;
  logic [XLEN-1:0] scalar1_q, scalar1_d;
  logic [XLEN-1:0] scalar2_q, scalar2_d;
  logic            rd_valid_q, rd_valid_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_idx;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] avl_reg;
  logic [XLEN-1:0] avl;
  logic [XLEN-1:0] vtype;
  logic            is_cfg;
  logic [2:0]      vlmul;
  logic [2:0]      vsew;
  logic            vtype_ok;
  logic [XLEN+3:0] vlmax_w;
  logic [XLEN-1:0] vl;

  assign opcode  = inst_q[6:0];
  assign funct3  = inst_q[14:12];
  assign rd_idx  = inst_q[11:7];
  assign rs1_idx = inst_q[19:15];

  // AVL source for the register forms: rs1, else all-ones, else keep current vl
  always_comb begin
    avl_reg = vlin_q;
    if (rs1_idx != 5'd0)     avl_reg = rs1_q;
    else if (rd_idx != 5'd0) avl_reg = '1;
  end

  // Instruction form decode: selects vtype and AVL source
  always_comb begin
    is_cfg = 1'b1;
    avl    = avl_reg;
    vtype  = '0;
    if (!inst_q[31]) begin
      vtype = XLEN'(inst_q[30:20]);
    end else if (inst_q[31:30] == 2'b11) begin
      vtype = XLEN'(inst_q[29:20]);
      avl   = XLEN'(inst_q[19:15]);
    end else if (inst_q[31:25] == 7'b1000000) begin
      vtype = rs2_q;
    end else begin
      is_cfg = 1'b0;
    end
    if (opcode != 7'h57 || funct3 != 3'b111) is_cfg = 1'b0;
  end

  assign vlmul    = vtype[2:0];
  assign vsew     = vtype[5:3];
  assign vtype_ok = (vlmul <= 3'd3) && (vsew <= 3'd3) &&
                    ((32'd8 << vsew) <= 32'(ELEN)) && (vtype[XLEN-1:8] == '0);

  // VLMAX computed with 4 spare bits so VLEN << vlmul cannot wrap
  always_comb begin
    vlmax_w = ((XLEN+4)'(VLEN) << vlmul) >> ({1'b0, vsew} + 4'd3);
    vl      = ((XLEN+4)'(avl) < vlmax_w) ? avl : vlmax_w[XLEN-1:0];
  end

  // Next-state and registered-output logic for the config FSM
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    vlin_d     = vlin_q;
    csrwr_en_d = 1'b0;
    scalar1_d  = scalar1_q;
    scalar2_d  = scalar2_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          inst_d  = inst;
          rs1_d   = rs1_data;
          rs2_d   = rs2_data;
          vlin_d  = vl_in;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // results land in the output flops so they are valid during WRITE
        state_d   = S_WRITE;
        rd_addr_d = rd_idx;
        if (!is_cfg) begin
          illegal_d = 1'b1;
          rd_data_d = '0;
        end else if (!vtype_ok) begin
          csrwr_en_d = 1'b1;
          scalar1_d  = '0;
          scalar2_d  = {1'b1, {(XLEN-1){1'b0}}};
          illegal_d  = 1'b1;
          rd_data_d  = '0;
        end else begin
          csrwr_en_d = 1'b1;
          scalar1_d  = vl;
          scalar2_d  = XLEN'(vtype[7:0]);
          illegal_d  = 1'b0;
          rd_data_d  = vl;
        end
      end
      S_WRITE: begin
        rd_valid_d = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inst_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      vlin_q     <= '0;
      csrwr_en_q <= 1'b0;
      scalar1_q  <= '0;
      scalar2_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      vlin_q     <= vlin_d;
      csrwr_en_q <= csrwr_en_d;
      scalar1_q  <= scalar1_d;
      scalar2_q  <= scalar2_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign inst_ready   = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign csrwr_en     = csrwr_en_q;
  assign scalar1      = scalar1_q;
  assign scalar2      = scalar2_q;
  assign rd_valid     = rd_valid_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;
  assign illegal_insn = illegal_q;

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Directed testbench for vec_vsetvl_unit.
module tb_vec_vsetvl_unit;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] vl_in;
  logic        csrwr_en;
  logic [31:0] scalar1;
  logic [31:0] scalar2;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        illegal_insn;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vec_vsetvl_unit #(.XLEN(32), .VLEN(512), .ELEN(64)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .vl_in(vl_in),
    .csrwr_en(csrwr_en), .scalar1(scalar1), .scalar2(scalar2),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .illegal_insn(illegal_insn), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_vsetvli(input logic [10:0] vt, input logic [4:0] rs1, input logic [4:0] rd);
    return {1'b0, vt, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetivli(input logic [9:0] vt, input logic [4:0] uimm, input logic [4:0] rd);
    return {2'b11, vt, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  // Full transaction with cycle-exact latency checks; entered and left at posedge+1 in IDLE.
  task automatic run_insn(input string nm, input logic [31:0] i, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] vli, input logic e_wr,
                          input logic [31:0] e_s1, input logic [31:0] e_s2, input logic [31:0] e_rd,
                          input logic [4:0] e_addr, input logic e_ill);
    total++;
    if (inst_ready !== 1'b1) begin bad++; $display("FAIL %s idle_ready got=%b exp=1", nm, inst_ready); end
    inst = i; rs1_data = r1; rs2_data = r2; vl_in = vli; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0; inst = '0; rs1_data = '0; rs2_data = '0; vl_in = '0;
    // CALC (N+1)
    total++;
    if (csrwr_en !== 1'b0 || busy !== 1'b1 || inst_ready !== 1'b0) begin
      bad++; $display("FAIL %s calc_ctrl got wr=%b busy=%b rdy=%b exp 0/1/0", nm, csrwr_en, busy, inst_ready);
    end
    @(posedge clk); #1;
    // WRITE (N+2)
    total++;
    if (csrwr_en !== e_wr || rd_valid !== 1'b0) begin
      bad++; $display("FAIL %s write_strobe got wr=%b rv=%b exp wr=%b rv=0", nm, csrwr_en, rd_valid, e_wr);
    end
    total++;
    if (scalar1 !== e_s1 || scalar2 !== e_s2) begin
      bad++; $display("FAIL %s scalars got s1=%h s2=%h exp s1=%h s2=%h", nm, scalar1, scalar2, e_s1, e_s2);
    end
    @(posedge clk); #1;
    // RESP (N+3)
    total++;
    if (rd_valid !== 1'b1 || csrwr_en !== 1'b0) begin
      bad++; $display("FAIL %s resp_valid got rv=%b wr=%b exp rv=1 wr=0", nm, rd_valid, csrwr_en);
    end
    total++;
    if (rd_data !== e_rd || rd_addr !== e_addr || illegal_insn !== e_ill) begin
      bad++; $display("FAIL %s resp got data=%h addr=%0d ill=%b exp data=%h addr=%0d ill=%b",
                      nm, rd_data, rd_addr, illegal_insn, e_rd, e_addr, e_ill);
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || inst_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after_hs got rv=%b rdy=%b busy=%b exp 0/1/0", nm, rd_valid, inst_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_valid = 1'b0; rd_ready = 1'b0;
    inst = '0; rs1_data = '0; rs2_data = '0; vl_in = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    total++;
    if (csrwr_en !== 1'b0 || rd_valid !== 1'b0 || illegal_insn !== 1'b0 || busy !== 1'b0 || inst_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl got wr=%b rv=%b ill=%b busy=%b rdy=%b exp 0/0/0/0/1",
                      csrwr_en, rd_valid, illegal_insn, busy, inst_ready);
    end
    total++;
    if (scalar1 !== 32'd0 || scalar2 !== 32'd0 || rd_data !== 32'd0 || rd_addr !== 5'd0) begin
      bad++; $display("FAIL reset_data got s1=%h s2=%h rd=%h addr=%0d exp all 0", scalar1, scalar2, rd_data, rd_addr);
    end
  endtask

  task automatic test_legal();
    // e32 m1: VLMAX = 512/32 = 16, AVL 100 -> 16
    run_insn("vsetvli_e32m1", enc_vsetvli(11'h010, 5'd5, 5'd1), 32'd100, 32'd0, 32'd0,
             1'b1, 32'd16, 32'h10, 32'd16, 5'd1, 1'b0);
    // e8 m8: VLMAX = 4096/8 = 512, AVL 5 -> 5
    run_insn("vsetivli_e8m8", enc_vsetivli(10'h003, 5'd5, 5'd2), 32'd0, 32'd0, 32'd0,
             1'b1, 32'd5, 32'h03, 32'd5, 5'd2, 1'b0);
    // vsetvl e64 m1 vta vma, rs1=x0 rd!=x0 -> AVL max, VLMAX 8
    run_insn("vsetvl_e64m1", enc_vsetvl(5'd6, 5'd0, 5'd3), 32'd0, 32'h0000_00D8, 32'd0,
             1'b1, 32'd8, 32'hD8, 32'd8, 5'd3, 1'b0);
  endtask

  task automatic test_keep_vl();
    // e16 m2: VLMAX = 1024/16 = 64; rs1=x0 rd=x0 reuses vl_in
    run_insn("keep_vl_7", enc_vsetvli(11'h009, 5'd0, 5'd0), 32'd0, 32'd0, 32'd7,
             1'b1, 32'd7, 32'h09, 32'd7, 5'd0, 1'b0);
    run_insn("keep_vl_100", enc_vsetvli(11'h009, 5'd0, 5'd0), 32'd0, 32'd0, 32'd100,
             1'b1, 32'd64, 32'h09, 32'd64, 5'd0, 1'b0);
  endtask

  task automatic test_illegal();
    run_insn("ill_vlmul5", enc_vsetvli(11'h005, 5'd5, 5'd4), 32'd100, 32'd0, 32'd0,
             1'b1, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b1);
    run_insn("ill_sew128", enc_vsetvli(11'h020, 5'd5, 5'd9), 32'd100, 32'd0, 32'd0,
             1'b1, 32'd0, 32'h8000_0000, 32'd0, 5'd9, 1'b1);
    run_insn("ill_rs2_100", enc_vsetvl(5'd7, 5'd5, 5'd6), 32'd50, 32'h0000_0100, 32'd0,
             1'b1, 32'd0, 32'h8000_0000, 32'd0, 5'd6, 1'b1);
    // legal write so the following bad opcode has non-zero scalars to hold
    run_insn("legal_pre", enc_vsetvli(11'h010, 5'd5, 5'd1), 32'd9, 32'd0, 32'd0,
             1'b1, 32'd9, 32'h10, 32'd9, 5'd1, 1'b0);
    // opcode 0x33: no CSR write, scalars hold previous values
    run_insn("bad_opcode", {12'h010, 5'd5, 3'b111, 5'd8, 7'h33}, 32'd100, 32'd0, 32'd0,
             1'b0, 32'd9, 32'h10, 32'd0, 5'd8, 1'b1);
  endtask

  task automatic test_backpressure();
    inst = enc_vsetvli(11'h010, 5'd5, 5'd1); rs1_data = 32'd100; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst = enc_vsetivli(10'h003, 5'd3, 5'd2); rs1_data = 32'd0;  // held valid, must be ignored
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned c = 0; c < 4; c++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 32'd16 || rd_addr !== 5'd1 || inst_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got rv=%b data=%0d addr=%0d rdy=%b exp 1/16/1/0",
                        c, rd_valid, rd_data, rd_addr, inst_ready);
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    // handshake edge must not also accept the waiting instruction
    total++;
    if (busy !== 1'b0 || inst_ready !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got busy=%b rdy=%b rv=%b exp 0/1/0", busy, inst_ready, rd_valid);
    end
    inst_valid = 1'b0;
    run_insn("b2b_next", enc_vsetivli(10'h003, 5'd3, 5'd2), 32'd0, 32'd0, 32'd0,
             1'b1, 32'd3, 32'h03, 32'd3, 5'd2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int unsigned wr_seen;
    wr_seen = 0;
    inst = enc_vsetvli(11'h010, 5'd5, 5'd1); rs1_data = 32'd100; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    rst = 1'b1;  // now in CALC
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || inst_ready !== 1'b1 || csrwr_en !== 1'b0 || scalar1 !== 32'd0) begin
      bad++; $display("FAIL rst_calc got busy=%b rdy=%b wr=%b s1=%0d exp 0/1/0/0", busy, inst_ready, csrwr_en, scalar1);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      if (csrwr_en !== 1'b0 || rd_valid !== 1'b0) wr_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (wr_seen != 0) begin
      bad++; $display("FAIL rst_no_write got events=%0d exp 0", wr_seen);
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_keep_vl();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
